// File: rtl/telemetry_frame_sender.sv
// Telemetry frame sender: on a host query byte, snapshots the matching sensor fields and streams
// header, MSB-first payload and an 8-bit additive checksum to the UART transmitter over a valid/ready link.
module telemetry_frame_sender #(
  parameter int unsigned INT_WIDTH = 8,
  parameter int unsigned N_WIDTH   = 32
) (
  input  logic                 MESSAGE_INTERPRETER_CLOCK_50,
  input  logic                 MESSAGE_INTERPRETER_RESET_InHigh,
  input  logic                 TFS_FLAGDATAIN_In,
  input  logic [INT_WIDTH-1:0] TFS_DATAIN_InBus,
  input  logic [N_WIDTH-1:0]   TFS_POSX_InBus,
  input  logic [N_WIDTH-1:0]   TFS_POSY_InBus,
  input  logic [N_WIDTH-1:0]   TFS_THETA_InBus,
  input  logic [INT_WIDTH-1:0] TFS_RPM1_InBus,
  input  logic [INT_WIDTH-1:0] TFS_RPM2_InBus,
  input  logic [INT_WIDTH-1:0] TFS_RPM3_InBus,
  input  logic [INT_WIDTH-1:0] TFS_RPM4_InBus,
  input  logic [N_WIDTH-1:0]   TFS_DIST1_InBus,
  input  logic [N_WIDTH-1:0]   TFS_DIST2_InBus,
  input  logic [N_WIDTH-1:0]   TFS_DIST3_InBus,
  input  logic [N_WIDTH-1:0]   TFS_DIST4_InBus,
  input  logic [INT_WIDTH-1:0] TFS_BEHAVIOR_InBus,
  input  logic [N_WIDTH-1:0]   TFS_IMUX_InBus,
  input  logic [N_WIDTH-1:0]   TFS_IMUY_InBus,
  input  logic [N_WIDTH-1:0]   TFS_IMUZ_InBus,
  input  logic                 TFS_TXREADY_In,
  output logic                 TFS_TXVALID_Out,
  output logic [INT_WIDTH-1:0] TFS_TXDATA_OutBus,
  output logic                 TFS_BUSY_Out,
  output logic                 TFS_OVERRUN_Out
);

  localparam int unsigned PAY_W = 4 * N_WIDTH;
  localparam int unsigned NB    = N_WIDTH / INT_WIDTH;
  localparam int unsigned CNT_W = $clog2(PAY_W / INT_WIDTH);

  localparam logic [INT_WIDTH-1:0] Q_POSE = INT_WIDTH'(8'h70);
  localparam logic [INT_WIDTH-1:0] Q_RPM  = INT_WIDTH'(8'h72);
  localparam logic [INT_WIDTH-1:0] Q_DIST = INT_WIDTH'(8'h64);
  localparam logic [INT_WIDTH-1:0] Q_BEH  = INT_WIDTH'(8'h62);
  localparam logic [INT_WIDTH-1:0] Q_IMU  = INT_WIDTH'(8'h6D);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HEADER   = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_CHECKSUM = 2'd3
  } state_t;

  state_t               state_q;
  logic                 flag_q;
  logic                 txvalid_q;
  logic [INT_WIDTH-1:0] txdata_q;
  logic                 busy_q;
  logic                 overrun_q;
  logic [PAY_W-1:0]     payload_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [INT_WIDTH-1:0] csum_q;

  logic                 is_query_c;
  logic [PAY_W-1:0]     snap_c;
  logic [CNT_W-1:0]     last_c;
  logic                 accept_c;
  logic                 xfer_c;
  logic [INT_WIDTH-1:0] csum_d;

  // Decode the query and build the left-aligned snapshot plus its last byte index
  always_comb begin
    is_query_c = 1'b1;
    snap_c     = '0;
    last_c     = '0;
    case (TFS_DATAIN_InBus)
      Q_POSE: begin
        snap_c = PAY_W'({TFS_POSX_InBus, TFS_POSY_InBus, TFS_THETA_InBus}) << N_WIDTH;
        last_c = CNT_W'(3 * NB - 1);
      end
      Q_RPM: begin
        snap_c = PAY_W'({TFS_RPM1_InBus, TFS_RPM2_InBus, TFS_RPM3_InBus, TFS_RPM4_InBus})
                 << (PAY_W - 4 * INT_WIDTH);
        last_c = CNT_W'(3);
      end
      Q_DIST: begin
        snap_c = {TFS_DIST1_InBus, TFS_DIST2_InBus, TFS_DIST3_InBus, TFS_DIST4_InBus};
        last_c = CNT_W'(4 * NB - 1);
      end
      Q_BEH: begin
        snap_c = PAY_W'(TFS_BEHAVIOR_InBus) << (PAY_W - INT_WIDTH);
        last_c = '0;
      end
      Q_IMU: begin
        snap_c = PAY_W'({TFS_IMUX_InBus, TFS_IMUY_InBus, TFS_IMUZ_InBus}) << N_WIDTH;
        last_c = CNT_W'(3 * NB - 1);
      end
      default: is_query_c = 1'b0;
    endcase
  end

  assign accept_c = TFS_FLAGDATAIN_In & ~flag_q & is_query_c;
  assign xfer_c   = txvalid_q & TFS_TXREADY_In;
  assign csum_d   = csum_q + txdata_q;

  // Frame sequencer; every output is a register updated only on transfer or accept
  always_ff @(posedge MESSAGE_INTERPRETER_CLOCK_50 or posedge MESSAGE_INTERPRETER_RESET_InHigh) begin
    if (MESSAGE_INTERPRETER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      flag_q    <= 1'b0;
      txvalid_q <= 1'b0;
      txdata_q  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      payload_q <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
    end else begin
      flag_q <= TFS_FLAGDATAIN_In;
      if (accept_c && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q   <= ST_HEADER;
            txvalid_q <= 1'b1;
            txdata_q  <= TFS_DATAIN_InBus;
            busy_q    <= 1'b1;
            payload_q <= snap_c;
            cnt_q     <= last_c;
            csum_q    <= '0;
          end
        end
        ST_HEADER: begin
          if (xfer_c) begin
            state_q   <= ST_PAYLOAD;
            txdata_q  <= payload_q[PAY_W-1 -: INT_WIDTH];
            payload_q <= payload_q << INT_WIDTH;
          end
        end
        ST_PAYLOAD: begin
          if (xfer_c) begin
            csum_q <= csum_d;
            if (cnt_q == '0) begin
              state_q  <= ST_CHECKSUM;
              txdata_q <= csum_d;
            end else begin
              txdata_q  <= payload_q[PAY_W-1 -: INT_WIDTH];
              payload_q <= payload_q << INT_WIDTH;
              cnt_q     <= cnt_q - CNT_W'(1);
            end
          end
        end
        ST_CHECKSUM: begin
          if (xfer_c) begin
            state_q   <= ST_IDLE;
            txvalid_q <= 1'b0;
            txdata_q  <= '0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TFS_TXVALID_Out   = txvalid_q;
  assign TFS_TXDATA_OutBus = txdata_q;
  assign TFS_BUSY_Out      = busy_q;
  assign TFS_OVERRUN_Out   = overrun_q;

endmodule

// File: tb/tb_telemetry_frame_sender.sv
// Directed bench for telemetry_frame_sender: drives queries, collects transferred bytes and
// compares whole frames and status flags against hand-computed expectations.
module tb_telemetry_frame_sender;

  logic        clk;
  logic        rst;
  logic        flag;
  logic [7:0]  din;
  logic [31:0] posx, posy, theta;
  logic [7:0]  rpm1, rpm2, rpm3, rpm4;
  logic [31:0] dist1, dist2, dist3, dist4;
  logic [7:0]  beh;
  logic [31:0] imux, imuy, imuz;
  logic        txready;
  logic        txvalid;
  logic [7:0]  txdata;
  logic        busy;
  logic        overrun;

  telemetry_frame_sender #(.INT_WIDTH(8), .N_WIDTH(32)) dut (
    .MESSAGE_INTERPRETER_CLOCK_50     (clk),
    .MESSAGE_INTERPRETER_RESET_InHigh (rst),
    .TFS_FLAGDATAIN_In                (flag),
    .TFS_DATAIN_InBus                 (din),
    .TFS_POSX_InBus                   (posx),
    .TFS_POSY_InBus                   (posy),
    .TFS_THETA_InBus                  (theta),
    .TFS_RPM1_InBus                   (rpm1),
    .TFS_RPM2_InBus                   (rpm2),
    .TFS_RPM3_InBus                   (rpm3),
    .TFS_RPM4_InBus                   (rpm4),
    .TFS_DIST1_InBus                  (dist1),
    .TFS_DIST2_InBus                  (dist2),
    .TFS_DIST3_InBus                  (dist3),
    .TFS_DIST4_InBus                  (dist4),
    .TFS_BEHAVIOR_InBus               (beh),
    .TFS_IMUX_InBus                   (imux),
    .TFS_IMUY_InBus                   (imuy),
    .TFS_IMUZ_InBus                   (imuz),
    .TFS_TXREADY_In                   (txready),
    .TFS_TXVALID_Out                  (txvalid),
    .TFS_TXDATA_OutBus                (txdata),
    .TFS_BUSY_Out                     (busy),
    .TFS_OVERRUN_Out                  (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cnt;
  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    flag = 1'b1;
    din  = b;
    step();
    flag = 1'b0;
  endtask

  // Collect one frame; optional toggling READY and a query injected at cycle inj_cyc
  task automatic get_frame(input bit toggle, input int inj_cyc, input logic [7:0] inj_byte);
    bit         ph = 1'b1;
    bit         hold = 1'b0;
    logic [7:0] held = 8'h00;
    int         cyc = 0;
    rxq.delete();
    busy_cnt = 0;
    while (cyc < 200) begin
      if (cyc == inj_cyc) begin
        flag = 1'b1;
        din  = inj_byte;
      end else if (cyc == inj_cyc + 1) begin
        flag = 1'b0;
      end
      txready = toggle ? ph : 1'b1;
      if (hold) begin
        chk("stall_valid", 32'(txvalid), 32'd1);
        chk("stall_data", 32'(txdata), 32'(held));
        hold = 1'b0;
      end
      if (!txvalid && rxq.size() > 0) break;
      if (busy) busy_cnt++;
      if (txvalid && txready) rxq.push_back(txdata);
      if (txvalid && !txready) begin
        hold = 1'b1;
        held = txdata;
      end
      step();
      ph = ~ph;
      cyc++;
    end
    txready = 1'b1;
    if (cyc >= 200) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, 32'(rxq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rxq.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rxq[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic idle_watch(input int n, input string tag);
    int vcnt = 0;
    for (int i = 0; i < n; i++) begin
      if (txvalid) vcnt++;
      step();
    end
    chk(tag, 32'(vcnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flag = 1'b0; din = 8'h00; txready = 1'b1;
    posx = 32'h01020304; posy = 32'h05060708; theta = 32'hFFFFFFFF;
    rpm1 = 8'h10; rpm2 = 8'h20; rpm3 = 8'h30; rpm4 = 8'h40;
    dist1 = 32'h11223344; dist2 = 32'h55667788; dist3 = 32'h99AABBCC; dist4 = 32'hDDEEFF00;
    beh = 8'h05;
    imux = 32'hA1A2A3A4; imuy = 32'hB1B2B3B4; imuz = 32'hC1C2C3C4;
    step(); step();
    chk("rst_valid", 32'(txvalid), 32'd0);
    chk("rst_data", 32'(txdata), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    step(); step();

    // RPM frame at full rate
    send_cmd(8'h72);
    chk("r_first_valid", 32'(txvalid), 32'd1);
    get_frame(1'b0, -10, 8'h00);
    exp_q = '{8'h72, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    cmp_frame("r");
    chk("r_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("r_busy_after", 32'(busy), 32'd0);
    step(); step();

    // Behaviour frame with flag held high for 20 cycles
    flag = 1'b1;
    din  = 8'h62;
    get_frame(1'b0, -10, 8'h00);
    exp_q = '{8'h62, 8'h05, 8'h05};
    cmp_frame("b");
    idle_watch(15, "b_no_retrigger");
    flag = 1'b0;
    chk("b_overrun", 32'(overrun), 32'd0);
    step(); step();

    // Pose frame with READY toggling
    send_cmd(8'h70);
    get_frame(1'b1, -10, 8'h00);
    exp_q = '{8'h70, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h20};
    cmp_frame("p");
    step(); step();

    // Non-query bytes are ignored
    send_cmd(8'h09); step();
    send_cmd(8'h0A); step();
    send_cmd(8'h41);
    chk("nq_valid", 32'(txvalid), 32'd0);
    idle_watch(4, "nq_valid_watch");
    chk("nq_busy", 32'(busy), 32'd0);
    chk("nq_overrun", 32'(overrun), 32'd0);

    // Distance frame; inputs change after accept and 'm' arrives mid-frame
    send_cmd(8'h64);
    dist1 = 32'hDEADBEEF; dist2 = 32'h0; dist3 = 32'h0; dist4 = 32'h12345678;
    get_frame(1'b0, 5, 8'h6D);
    exp_q = '{8'h64, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'hF8};
    cmp_frame("d");
    chk("d_overrun", 32'(overrun), 32'd1);
    idle_watch(10, "d_no_m_frame");
    step();

    // IMU frame aborted by reset at payload byte 5, then resent
    send_cmd(8'h6D);
    for (int i = 0; i < 5; i++) step();
    chk("m_byte5", 32'(txdata), 32'hB1);
    rst = 1'b1;
    #1;
    chk("m_rst_valid", 32'(txvalid), 32'd0);
    chk("m_rst_busy", 32'(busy), 32'd0);
    chk("m_rst_data", 32'(txdata), 32'h00);
    chk("m_rst_overrun", 32'(overrun), 32'd0);
    step();
    rst = 1'b0;
    step();
    send_cmd(8'h6D);
    get_frame(1'b0, -10, 8'h00);
    exp_q = '{8'h6D, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
              8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h5E};
    cmp_frame("m");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
